// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the RV32I fetch front end.
// Imported by the fetch top and its queue.
package instruction_fetch_pkg;

    localparam int INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int FETCH_QUEUE_DEPTH = 2;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush_i,
    input  logic                           wr_en_i,
    input  logic [WIDTH-1:0]               wr_data_i,
    input  logic                           rd_en_i,
    output logic [WIDTH-1:0]               rd_data_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH):0]         count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    assign pop  = rd_en_i && (count_q != '0);
    // A full queue still accepts a write when the head leaves this cycle.
    assign push = wr_en_i && ((count_q != CW'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch front end: PC, in-order imem reads, fetch queue,
// stall hold and redirect flush.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = FETCH_QUEUE_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [XLEN-1:0]       imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  system_stall,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [XLEN-1:0]       instruction_pc,
    output logic                  instruction_valid,
    output logic                  misaligned_redirect
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = INST_WIDTH + XLEN;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] rsp_pc_d;
    logic [XLEN-1:0] last_pc_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   inflight_d;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   drop_d;
    logic            misaligned_q;
    logic            gate_q;

    logic [CW-1:0]   occupancy;
    logic            q_empty;
    logic [QW-1:0]   q_head;
    logic [XLEN-1:0] target_pc;
    logic [CW:0]     credit;
    logic            fire;
    logic            enq;
    logic            deq;
    logic            head_valid;

    assign target_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign head_valid = !q_empty && !gate_q;
    assign deq        = head_valid && !system_stall && !redirect_valid;
    assign enq        = imem_rvalid && (drop_q == '0) && !redirect_valid;

    // A head leaving this cycle frees its slot for a new request.
    assign credit = {1'b0, occupancy} + {1'b0, inflight_q}
                  - {{CW{1'b0}}, deq};

    assign imem_req  = !reset && !redirect_valid && (credit < DEPTH_W);
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_ready;

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CW'(fire) - CW'(imem_rvalid);
        if (redirect_valid) begin
            pc_d     = target_pc;
            rsp_pc_d = target_pc;
            drop_d   = inflight_q - CW'(imem_rvalid);
        end else begin
            if (fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (enq) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            last_pc_q    <= RESET_PC;
            inflight_q   <= '0;
            drop_q       <= '0;
            misaligned_q <= 1'b0;
            gate_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            rsp_pc_q     <= rsp_pc_d;
            last_pc_q    <= instruction_pc;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            misaligned_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            // An empty output seen under stall stays empty until release.
            gate_q       <= system_stall && (!head_valid || redirect_valid);
        end
    end

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (redirect_valid),
        .wr_en_i   (enq),
        .wr_data_i ({imem_rdata, rsp_pc_q}),
        .rd_en_i   (deq),
        .rd_data_o (q_head),
        .empty_o   (q_empty),
        .count_o   (occupancy)
    );

    assign instruction_valid   = head_valid;
    assign instruction         = head_valid ? q_head[QW-1 -: INST_WIDTH]
                                            : NOP_INSTR;
    assign instruction_pc      = head_valid ? q_head[XLEN-1:0] : last_pc_q;
    assign misaligned_redirect = misaligned_q;

endmodule
